// File: rtl/cpu_pkg.sv
// cpu_pkg: shared op/state types and width defaults for reg_xfer_ctrl; REG_XFER_SWAP_EN adds SWAP states
package cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

`ifdef REG_XFER_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_LDI  = 2'd0,
        OP_RD   = 2'd1,
        OP_MOV  = 2'd2,
        OP_SWAP = 2'd3
    } xfer_op_e;

`ifdef REG_XFER_SWAP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR_D,
        S_WR_S
    } xfer_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_A,
        S_WR_D
    } xfer_state_e;
`endif

    // SWAP is only a legal op when the swap datapath is built
    function automatic logic op_legal(input xfer_op_e op);
        return (op != OP_SWAP) || SWAP_EN;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a one-bit priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    // pointer decides only when both compete; a lone requester always wins
    always_comb gnt_o = (&valid_i) ? (ptr_q ? 2'b10 : 2'b01) : valid_i;

    // after a grant, priority passes to the requester that did not win
    always_ff @(posedge clk) begin
        if (!rst)
            ptr_q <= 1'b0;
        else if (adv_i)
            ptr_q <= gnt_o[0];
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: arbitrates two requesters and sequences register-file bus phases; REG_XFER_SWAP_EN enables SWAP
module reg_xfer_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_op,
    input  logic [2*ADDR_W-1:0] req_src,
    input  logic [2*ADDR_W-1:0] req_dst,
    input  logic [2*DATA_W-1:0] req_imm,
    output logic [ADDR_W-1:0]   rf_store,
    output logic                rf_ren,
    output logic                rf_wen,
    output logic [DATA_W-1:0]   rf_in,
    input  logic [DATA_W-1:0]   bus_data,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                err,
    output logic                busy
);

    logic [1:0]        gnt;
    logic              hs;
    logic              sel;
    xfer_op_e          op_sel;
    logic [ADDR_W-1:0] src_sel;
    logic [ADDR_W-1:0] dst_sel;
    logic [DATA_W-1:0] imm_sel;

    xfer_state_e       state_q;
    xfer_op_e          op_q;
    logic [ADDR_W-1:0] dst_q;
    logic              id_q;
    logic [DATA_W-1:0] t0_q;
`ifdef REG_XFER_SWAP_EN
    logic [ADDR_W-1:0] src_q;
    logic [DATA_W-1:0] t1_q;
`endif

    logic [ADDR_W-1:0] rf_store_q;
    logic              rf_ren_q;
    logic              rf_wen_q;
    logic [DATA_W-1:0] rf_in_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic              err_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i (req_valid),
        .adv_i   (hs),
        .gnt_o   (gnt)
    );

    // mux the granted requester's command fields; ready only in IDLE and never while in reset
    always_comb begin
        sel       = gnt[1];
        op_sel    = xfer_op_e'(sel ? req_op[3:2] : req_op[1:0]);
        src_sel   = sel ? req_src[2*ADDR_W-1:ADDR_W] : req_src[ADDR_W-1:0];
        dst_sel   = sel ? req_dst[2*ADDR_W-1:ADDR_W] : req_dst[ADDR_W-1:0];
        imm_sel   = sel ? req_imm[2*DATA_W-1:DATA_W] : req_imm[DATA_W-1:0];
        req_ready = (state_q == S_IDLE && rst) ? gnt : 2'b00;
        hs        = |(req_valid & req_ready);
    end

    assign rf_store  = rf_store_q;
    assign rf_ren    = rf_ren_q;
    assign rf_wen    = rf_wen_q;
    assign rf_in     = rf_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_valid_q ? t0_q : '0;
    assign err       = err_q;
    assign busy      = state_q != S_IDLE;

    // sequencer: each transition also loads the bus-phase outputs of the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LDI;
            dst_q       <= '0;
            id_q        <= 1'b0;
            t0_q        <= '0;
`ifdef REG_XFER_SWAP_EN
            src_q       <= '0;
            t1_q        <= '0;
`endif
            rf_store_q  <= '0;
            rf_ren_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rf_store_q  <= '0;
            rf_ren_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: if (hs) begin
                    op_q  <= op_sel;
                    dst_q <= dst_sel;
                    id_q  <= sel;
`ifdef REG_XFER_SWAP_EN
                    src_q <= src_sel;
`endif
                    if (op_sel == OP_LDI) begin
                        state_q    <= S_WR_D;
                        rf_store_q <= dst_sel;
                        rf_in_q    <= imm_sel;
                        rf_wen_q   <= 1'b1;
                    end else if (op_legal(op_sel)) begin
                        state_q    <= S_RD_A;
                        rf_store_q <= src_sel;
                        rf_ren_q   <= 1'b1;
                    end else begin
                        err_q      <= 1'b1;
                    end
                end
                S_RD_A: begin
                    t0_q <= bus_data;
                    if (op_q == OP_RD) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
`ifdef REG_XFER_SWAP_EN
                    end else if (op_q == OP_SWAP) begin
                        state_q    <= S_RD_B;
                        rf_store_q <= dst_q;
                        rf_ren_q   <= 1'b1;
`endif
                    end else begin
                        state_q    <= S_WR_D;
                        rf_store_q <= dst_q;
                        rf_in_q    <= bus_data;
                        rf_wen_q   <= 1'b1;
                    end
                end
`ifdef REG_XFER_SWAP_EN
                S_RD_B: begin
                    t1_q       <= bus_data;
                    state_q    <= S_WR_D;
                    rf_store_q <= dst_q;
                    rf_in_q    <= t0_q;
                    rf_wen_q   <= 1'b1;
                end
                S_WR_D: if (op_q == OP_SWAP) begin
                    state_q    <= S_WR_S;
                    rf_store_q <= src_q;
                    rf_in_q    <= t1_q;
                    rf_wen_q   <= 1'b1;
                end else begin
                    state_q    <= S_IDLE;
                end
                S_WR_S: state_q <= S_IDLE;
`else
                S_WR_D: state_q <= S_IDLE;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Sequencer and arbiter for the primary 8-entry register file and its shared 8-bit data bus. It takes register-transfer commands from two requesters (requester 0: control FSM decode; requester 1: debug/loader port) and grants them round-robin. It breaks each command into single-cycle bus phases by driving the register file's `store`/`rEN`/`wEN`/`in`, and returns read data to the requester. Only one bus phase is active in any cycle, so the register file never sees `rEN` and `wEN` together.

## Interface
- `DATA_W`, 8, data bus / register width
- `ADDR_W`, 3, register index width (8 registers)
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `req_valid`  in  2  per-requester command valid
- `req_ready`  out  2  per-requester accept; handshake = valid & ready on a rising edge
- `req_op`  in  4  2 bits per requester: 0 LDI, 1 RD, 2 MOV, 3 SWAP (see Configuration)
- `req_src`  in  6  3 bits per requester, source register
- `req_dst`  in  6  3 bits per requester, destination register
- `req_imm`  in  16  8 bits per requester, LDI immediate
- `rf_store`  out  ADDR_W  register index to register file
- `rf_ren`  out  1  register file drives data bus
- `rf_wen`  out  1  register file captures `rf_in` via data bus
- `rf_in`  out  DATA_W  write data
- `bus_data`  in  DATA_W  data bus value, sampled during read phases
- `rsp_valid`  out  1  one-cycle pulse: RD result
- `rsp_id`  out  1  requester that issued the RD
- `rsp_data`  out  DATA_W  RD result
- `err`  out  1  one-cycle pulse: illegal op accepted
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RD_A, RD_B, WR_D, WR_S. Temporaries `t0`, `t1` (DATA_W each).
- IDLE: the arbiter picks among valid requesters. `req_ready` is high only for the winner and only in IDLE. On handshake, latch op/src/dst/imm/id.
- LDI: IDLE → WR_D (store=dst, in=imm, wen=1) → IDLE.
- RD: IDLE → RD_A (store=src, ren=1, t0←bus_data) → IDLE. `rsp_valid`=1 in that IDLE cycle, with `rsp_data`=t0 and `rsp_id` set.
- MOV: IDLE → RD_A (t0←R[src]) → WR_D (R[dst]←t0) → IDLE.
- SWAP: IDLE → RD_A (t0←R[src]) → RD_B (store=dst, t1←bus_data) → WR_D (R[dst]←t0) → WR_S (store=src, in=t1) → IDLE.
- Illegal op: IDLE → IDLE. No bus phase. `err`=1 in the next cycle.
- src==dst: executed normally. MOV and SWAP leave the register unchanged.
- Arbitration: 2-way round-robin. The pointer moves to the other requester after each grant. If only one requester is valid, it wins regardless of the pointer.
- `rf_store`/`rf_in`/`rf_ren`/`rf_wen` decode only from registered state/latches. There is no combinational path from `req_*` to `rf_*`.
- Outside phases: ren=wen=0, store=0, in=0.

## Timing
- Reset (rst low at a rising edge): state IDLE, pointer favours requester 0, t0=t1=0. All outputs 0: req_ready, rf_*, rsp_*, err, busy. `req_ready` stays 0 during the reset cycle.
- Reset mid-operation: the in-flight command is dropped with no response and no further bus phases. Phases already committed are not undone.
- Latency from handshake edge to IDLE: LDI 1, RD 1 (rsp in the IDLE cycle), MOV 2, SWAP 4, illegal 0.
- Back-to-back: a new handshake can occur in the same IDLE cycle that carries `rsp_valid` or `err`.
- `req_valid` may drop without handshake. No command is latched in that case.

## Configuration
- `REG_XFER_SWAP_EN` defined: op 3 = SWAP, and states RD_B and WR_S exist.
- Not defined: op 3 is illegal (`err` pulse, no bus activity), and RD_B/WR_S are not built.

## Structure
- `cpu_pkg`: `xfer_op_e` (LDI, RD, MOV, SWAP), `xfer_state_e`, and the `DATA_W`/`ADDR_W` defaults.
- Sub-module `rr_arb2`: 2-way round-robin arbiter. It takes valid[1:0] and an advance strobe and outputs a one-hot grant. It holds the pointer and shares the same clk/rst.

## Test plan
- Reset, then requester 0 issues LDI R3←0xA5 → one cycle with store=3, wen=1, in=0xA5; busy 1 cycle; R3=0xA5.
- Preload R3=0xA5, then MOV R3→R6 → RD_A (store=3, ren=1), WR_D (store=6, in=0xA5); never ren & wen together.
- RD R6 after the MOV → `rsp_valid` 1 cycle, `rsp_data`=0xA5, `rsp_id` = issuer.
- Both requesters continuously issue LDI → grants alternate 0,1,0,1. Requester 1 alone keeps winning.
- With SWAP_EN, R1=0x11, R2=0x22, SWAP 1,2 → R1=0x22, R2=0x11 after 4 phases. Without SWAP_EN, op 3 → `err` pulse, no rf activity.
- rst low during the RD_A of a MOV → next cycle IDLE, wen never asserted, destination unchanged, no rsp.
